// File: rtl/rgb_block_collector.sv
// Collects NPIX raster-order RGB pixels into flat per-colour blocks and hands
// each complete block downstream through a valid/ready handshake.
module rgb_block_collector #(
  parameter int NPIX = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sob,
  input  logic [7:0]        in_r,
  input  logic [7:0]        in_g,
  input  logic [7:0]        in_b,
  output logic [8*NPIX-1:0] r_all,
  output logic [8*NPIX-1:0] g_all,
  output logic [8*NPIX-1:0] b_all,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic [6:0]        fill_count,
  output logic [15:0]       blk_count,
  output logic              err_resync
);

  localparam int AW = (NPIX > 1) ? $clog2(8 * NPIX) : 3;
  localparam logic [6:0] LAST = 7'(NPIX - 1);

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [6:0]        fill_count_q, fill_count_d;
  logic [15:0]       blk_count_q, blk_count_d;
  logic              err_resync_q, err_resync_d;
  logic [8*NPIX-1:0] r_all_q, r_all_d;
  logic [8*NPIX-1:0] g_all_q, g_all_d;
  logic [8*NPIX-1:0] b_all_q, b_all_d;

  logic              accept_s;
  logic              resync_s;
  logic              last_s;
  logic [6:0]        slot_s;
  logic [AW-1:0]     base_s;

  // A start-of-block seen mid-block restarts the tile at slot 0.
  assign accept_s = in_valid && in_ready;
  assign resync_s = accept_s && in_sob && (fill_count_q != 7'd0);
  assign last_s   = (fill_count_q == LAST);
  assign slot_s   = resync_s ? 7'd0 : fill_count_q;
  assign base_s   = AW'({slot_s, 3'b000});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (accept_s && !resync_s && last_s) begin
          state_d = FULL;
        end else begin
          state_d = FILL;
        end
      end
      FULL: begin
        if (blk_ready) begin
          state_d = FILL;
        end else begin
          state_d = FULL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == FILL);
    blk_valid = (state_q == FULL);
  end

  always_comb begin
    fill_count_d = fill_count_q;
    blk_count_d  = blk_count_q;
    err_resync_d = err_resync_q;
    r_all_d      = r_all_q;
    g_all_d      = g_all_q;
    b_all_d      = b_all_q;
    if (accept_s) begin
      r_all_d[base_s +: 8] = in_r;
      g_all_d[base_s +: 8] = in_g;
      b_all_d[base_s +: 8] = in_b;
      if (resync_s) begin
        fill_count_d = 7'd1;
        err_resync_d = 1'b1;
      end else if (last_s) begin
        fill_count_d = 7'd0;
      end else begin
        fill_count_d = fill_count_q + 7'd1;
      end
    end else begin
      fill_count_d = fill_count_q;
    end
    if ((state_q == FULL) && blk_ready) begin
      blk_count_d = blk_count_q + 16'd1;
    end else begin
      blk_count_d = blk_count_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_count_q <= 7'd0;
      blk_count_q  <= 16'd0;
      err_resync_q <= 1'b0;
      r_all_q      <= '0;
      g_all_q      <= '0;
      b_all_q      <= '0;
    end else begin
      fill_count_q <= fill_count_d;
      blk_count_q  <= blk_count_d;
      err_resync_q <= err_resync_d;
      r_all_q      <= r_all_d;
      g_all_q      <= g_all_d;
      b_all_q      <= b_all_d;
    end
  end

  assign r_all      = r_all_q;
  assign g_all      = g_all_q;
  assign b_all      = b_all_q;
  assign fill_count = fill_count_q;
  assign blk_count  = blk_count_q;
  assign err_resync = err_resync_q;

endmodule

// File: tb/tb_rgb_block_collector.sv
// Self-checking bench for rgb_block_collector: directed scenarios plus a
// randomized stream compared against a block-level reference model.
module tb_rgb_block_collector;

  localparam int NPIX = 64;
  localparam int VW   = 8 * NPIX;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_sob = 1'b0;
  logic [7:0]    in_r = 8'd0;
  logic [7:0]    in_g = 8'd0;
  logic [7:0]    in_b = 8'd0;
  logic          blk_ready = 1'b0;
  logic          in_ready;
  logic          blk_valid;
  logic [VW-1:0] r_all;
  logic [VW-1:0] g_all;
  logic [VW-1:0] b_all;
  logic [6:0]    fill_count;
  logic [15:0]   blk_count;
  logic          err_resync;

  rgb_block_collector #(.NPIX(NPIX)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sob(in_sob), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .r_all(r_all), .g_all(g_all), .b_all(b_all),
    .blk_valid(blk_valid), .blk_ready(blk_ready),
    .fill_count(fill_count), .blk_count(blk_count), .err_resync(err_resync)
  );

  always #5 clk = ~clk;

  // Reference model: the tile buffer, write index, pending-block flag, counters.
  logic [7:0] m_r [NPIX];
  logic [7:0] m_g [NPIX];
  logic [7:0] m_b [NPIX];
  int         m_idx;
  bit         m_full;
  int         m_cnt;
  bit         m_err;
  int         m_hand;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NPIX; i++) begin
      m_r[i] = 8'd0; m_g[i] = 8'd0; m_b[i] = 8'd0;
    end
    m_idx = 0; m_full = 1'b0; m_cnt = 0; m_err = 1'b0; m_hand = 0;
  endtask

  task automatic model_edge();
    if (!m_full) begin
      if (in_valid) begin
        if (in_sob && m_idx != 0) begin
          m_r[0] = in_r; m_g[0] = in_g; m_b[0] = in_b;
          m_idx = 1;
          m_err = 1'b1;
        end else begin
          m_r[m_idx] = in_r; m_g[m_idx] = in_g; m_b[m_idx] = in_b;
          m_idx++;
          if (m_idx == NPIX) begin
            m_idx  = 0;
            m_full = 1'b1;
          end
        end
      end
    end else if (blk_ready) begin
      m_full = 1'b0;
      m_cnt  = (m_cnt + 1) % 65536;
      m_hand++;
    end
  endtask

  task automatic check_all(input string ph);
    logic [VW-1:0] er, eg, eb;
    check_eq({ph, "_in_ready"}, VW'(in_ready), VW'(!m_full));
    check_eq({ph, "_blk_valid"}, VW'(blk_valid), VW'(m_full));
    check_eq({ph, "_fill_count"}, VW'(fill_count), VW'(m_idx));
    check_eq({ph, "_blk_count"}, VW'(blk_count), VW'(m_cnt));
    check_eq({ph, "_err_resync"}, VW'(err_resync), VW'(m_err));
    if (m_full) begin
      for (int i = 0; i < NPIX; i++) begin
        er[i*8 +: 8] = m_r[i]; eg[i*8 +: 8] = m_g[i]; eb[i*8 +: 8] = m_b[i];
      end
      check_eq({ph, "_r_all"}, r_all, er);
      check_eq({ph, "_g_all"}, g_all, eg);
      check_eq({ph, "_b_all"}, b_all, eb);
    end
  endtask

  task automatic cyc(input string ph, input logic v, input logic s, input logic [7:0] r,
                     input logic [7:0] g, input logic [7:0] b, input logic br);
    in_valid = v; in_sob = s; in_r = r; in_g = g; in_b = b; blk_ready = br;
    @(posedge clk);
    model_edge();
    #1;
    check_all(ph);
  endtask

  task automatic rand_pix(input string ph, input int n, input logic br);
    for (int i = 0; i < n; i++) begin
      cyc(ph, 1'b1, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), br);
    end
  endtask

  // Pulses reset mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset(input string ph);
    rst_n = 1'b0; in_valid = 1'b1; in_sob = 1'b0; in_r = 8'h5A; in_g = 8'hA5; in_b = 8'h3C; blk_ready = 1'b1;
    model_reset();
    #1;
    check_all({ph, "_async"});
    check_eq({ph, "_async_r_all"}, r_all, '0);
    check_eq({ph, "_async_b_all"}, b_all, '0);
    @(posedge clk);
    #1;
    check_all({ph, "_held"});
    check_eq({ph, "_held_g_all"}, g_all, '0);
    rst_n = 1'b1;
  endtask

  initial begin
    int cycles;
    #3;
    do_reset("rst0");

    // Ramp block with continuous downstream acceptance.
    for (int i = 0; i < NPIX; i++) begin
      cyc("t1", 1'b1, (i == 0), 8'(i), 8'(2 * i), 8'(255 - i), 1'b1);
    end
    check_eq("t1_valid_after_last", VW'(blk_valid), VW'(1'b1));
    check_eq("t1_bubble_ready", VW'(in_ready), VW'(1'b0));
    for (int i = 0; i < NPIX; i++) begin
      check_eq("t1_r_byte", VW'(r_all[i*8 +: 8]), VW'(8'(i)));
    end
    cyc("t1h", 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
    check_eq("t1_valid_one_cycle", VW'(blk_valid), VW'(1'b0));
    check_eq("t1_blk_count", VW'(blk_count), VW'(16'd1));

    // Downstream stall: block held, pixels refused.
    rand_pix("t2f", NPIX, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc("t2s", 1'($urandom), 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      check_eq("t2_stall_valid", VW'(blk_valid), VW'(1'b1));
    end
    cyc("t2h", 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
    check_eq("t2_release", VW'(blk_valid), VW'(1'b0));
    check_eq("t2_blk_count", VW'(blk_count), VW'(16'd2));

    // Premature start-of-block after 20 pixels.
    cyc("t3f", 1'b1, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
    rand_pix("t3f", 19, 1'b1);
    cyc("t3s", 1'b1, 1'b1, 8'hAA, 8'h11, 8'h22, 1'b1);
    check_eq("t3_err", VW'(err_resync), VW'(1'b1));
    check_eq("t3_fill", VW'(fill_count), VW'(7'd1));
    check_eq("t3_slot0", VW'(r_all[7:0]), VW'(8'hAA));
    rand_pix("t3c", NPIX - 1, 1'b1);
    check_eq("t3_complete", VW'(blk_valid), VW'(1'b1));
    cyc("t3h", 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
    check_eq("t3_blk_count", VW'(blk_count), VW'(16'd3));
    check_eq("t3_err_sticky", VW'(err_resync), VW'(1'b1));

    // Reset in the middle of a block discards it.
    rand_pix("t4p", 40, 1'b1);
    do_reset("t4r");
    rand_pix("t4f", NPIX, 1'b1);
    cyc("t4h", 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
    check_eq("t4_blk_count", VW'(blk_count), VW'(16'd1));

    // Randomized stream over 1000 blocks.
    do_reset("t5r");
    cycles = 0;
    while (m_hand < 1000 && cycles < 300000) begin
      cyc("t5", 1'($urandom), (m_idx == 0) && 1'($urandom), 8'($urandom), 8'($urandom),
          8'($urandom), ($urandom_range(0, 3) != 0));
      cycles++;
    end
    check_eq("t5_handoffs", VW'(m_hand), VW'(1000));
    check_eq("t5_blk_count", VW'(blk_count), VW'(16'(1000)));
    check_eq("t5_err_clear", VW'(err_resync), VW'(1'b0));

    // Counter wrap.
    while (m_full || m_idx != 0) begin
      cyc("t6d", 1'b1, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
    end
    force dut.blk_count_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    #1;
    release dut.blk_count_q;
    rand_pix("t6f", NPIX, 1'b1);
    cyc("t6h", 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
    check_eq("t6_wrap", VW'(blk_count), VW'(16'h0000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
